multicycle_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the existing register-file/ALU datapath and the instruction fetch path. It replaces the single-cycle control path with a FETCH/DECODE/EXECUTE/WRITEBACK sequence. It waits on an instruction-memory valid handshake and decodes R-type and I-type ALU instructions into the 4-bit ALU control code. It gates register writes and PC advance, and stops on ECALL (halt), on an illegal encoding, or on a fetch timeout (trap).

---
 rtl/rv_ctrl_pkg.sv | 35 +++
 rtl/multicycle_sequencer_alu_decoder.sv | 67 ++++++
 rtl/multicycle_sequencer.sv | 118 +++++++++++
 tb/tb_multicycle_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared control constants for the multi-cycle sequencer and the datapath ALU.
package rv_ctrl_pkg;

  localparam logic [6:0]  OP_R       = 7'b0110011;
  localparam logic [6:0]  OP_I       = 7'b0010011;
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4,
    ST_TRAP      = 3'd5
  } seq_state_t;

endpackage

// File: rtl/multicycle_sequencer_alu_decoder.sv
// Combinational decode of R/I-type ALU instructions into the 4-bit ALU code.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control,
  output logic       alu_src_imm,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    alu_src_imm = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  alu_control = ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  alu_control = ALU_SUB;
            3'b101:  alu_control = ALU_SRA;
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      // I-type: funct7 only matters for the shift-immediate forms
      OP_I: begin
        alu_src_imm = 1'b1;
        case (funct3)
          3'b000: alu_control = ALU_ADD;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          3'b001: begin
            if (funct7 == F7_ZERO) alu_control = ALU_SLL;
            else                   illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_ZERO)     alu_control = ALU_SRL;
            else if (funct7 == F7_ALT) alu_control = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXECUTE/WRITEBACK control FSM with fetch timeout, halt and trap.
module multicycle_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_valid,
  input  logic [31:0]      inst_code,
  output logic             imem_req,
  output logic             ir_load,
  output logic [3:0]       alu_control,
  output logic             alu_src_imm,
  output logic             write_on_register,
  output logic             pc_enable,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  seq_state_t       state;
  logic [7:0]       wait_cnt;
  logic [31:0]      ir;
  logic [3:0]       alu_ctl_q;
  logic             src_imm_q;
  logic             halted_q;
  logic             trap_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] instret_q;

  logic [3:0] dec_alu;
  logic       dec_imm;
  logic       dec_illegal;

  alu_decoder u_alu_decoder (
    .opcode      (ir[6:0]),
    .funct3      (ir[14:12]),
    .funct7      (ir[31:25]),
    .alu_control (dec_alu),
    .alu_src_imm (dec_imm),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      wait_cnt  <= 8'd0;
      ir        <= 32'd0;
      alu_ctl_q <= 4'd0;
      src_imm_q <= 1'b0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      instret_q <= {CNT_W{1'b0}};
    end else begin
      case (state)
        // valid wins over the timeout on the last allowed wait cycle
        ST_FETCH: begin
          if (imem_valid) begin
            ir       <= inst_code;
            wait_cnt <= 8'd0;
            state    <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 8'd0;
            trap_q   <= 1'b1;
            cause_q  <= CAUSE_TIMEOUT;
            state    <= ST_TRAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
          if (ir == INST_ECALL) begin
            halted_q <= 1'b1;
            state    <= ST_HALT;
          end else if (dec_illegal) begin
            trap_q  <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
            state   <= ST_TRAP;
          end else begin
            alu_ctl_q <= dec_alu;
            src_imm_q <= dec_imm;
            state     <= ST_EXECUTE;
          end
        end
        ST_EXECUTE:   state <= ST_WRITEBACK;
        ST_WRITEBACK: begin
          instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state     <= ST_FETCH;
        end
        ST_HALT:      state <= ST_HALT;
        ST_TRAP:      state <= ST_TRAP;
        default:      state <= ST_FETCH;
      endcase
    end
  end

  // Strobes are masked while reset is held so every output reads 0 under reset
  logic in_alu_phase;
  assign in_alu_phase = !reset && ((state == ST_EXECUTE) || (state == ST_WRITEBACK));

  assign imem_req          = !reset && (state == ST_FETCH);
  assign ir_load           = imem_req && imem_valid;
  assign alu_control       = in_alu_phase ? alu_ctl_q : 4'd0;
  assign alu_src_imm       = in_alu_phase && src_imm_q;
  assign pc_enable         = !reset && (state == ST_WRITEBACK);
  assign write_on_register = pc_enable && (ir[11:7] != 5'd0);
  assign halted            = halted_q;
  assign trap              = trap_q;
  assign trap_cause        = cause_q;
  assign instret           = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Table-driven cycle-by-cycle checks plus directed corner-case sequences.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid = 1'b0;
  logic [31:0] inst_code = 32'd0;
  logic        imem_req, ir_load, alu_src_imm, write_on_register, pc_enable, halted, trap;
  logic [3:0]  alu_control;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  multicycle_sequencer #(.FETCH_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .imem_valid(imem_valid), .inst_code(inst_code),
    .imem_req(imem_req), .ir_load(ir_load), .alu_control(alu_control),
    .alu_src_imm(alu_src_imm), .write_on_register(write_on_register),
    .pc_enable(pc_enable), .halted(halted), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        load;
    logic [3:0]  alu;
    logic        imm;
    logic        wr;
    logic        pc;
    logic        halted;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] instret;
  } outs_t;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] inst;
    outs_t       exp;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  localparam logic [31:0] I_ADD   = 32'h0020_81B3;
  localparam logic [31:0] I_ECALL = 32'h0000_0073;

  function automatic outs_t mk(input logic req, input logic load, input logic [3:0] alu,
                               input logic imm, input logic wr, input logic pc,
                               input logic h, input logic t, input logic [1:0] c,
                               input logic [31:0] cnt);
    outs_t o;
    o.req = req; o.load = load; o.alu = alu; o.imm = imm; o.wr = wr; o.pc = pc;
    o.halted = h; o.trap = t; o.cause = c; o.instret = cnt;
    return o;
  endfunction

  function automatic outs_t actual();
    return mk(imem_req, ir_load, alu_control, alu_src_imm, write_on_register,
              pc_enable, halted, trap, trap_cause, instret);
  endfunction

  function automatic void push(input logic r, input logic v, input logic [31:0] i, input outs_t e);
    vec_t x;
    x.rst = r; x.vld = v; x.inst = i; x.exp = e;
    vecs.push_back(x);
  endfunction

  // One instruction = FETCH, DECODE, EXECUTE, WRITEBACK rows; junk on the bus after FETCH
  function automatic void add_instr(input logic [31:0] inst, input logic [3:0] alu,
                                    input logic imm, input logic wr);
    push(1'b0, 1'b1, inst,          mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, exp_cnt));
    push(1'b0, 1'b1, 32'hFFFF_FFFF, mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, exp_cnt));
    push(1'b0, 1'b0, 32'd0,         mk(1'b0, 1'b0, alu,  imm,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, exp_cnt));
    push(1'b0, 1'b0, 32'd0,         mk(1'b0, 1'b0, alu,  imm,  wr,   1'b1, 1'b0, 1'b0, 2'd0, exp_cnt));
    exp_cnt = exp_cnt + 32'd1;
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [31:0] i);
    @(posedge clk);
    #1;
    reset = r; imem_valid = v; inst_code = i;
    @(negedge clk);
  endtask

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got req=%b load=%b alu=%b imm=%b wr=%b pc=%b halt=%b trap=%b cause=%b cnt=%0d ; expected req=%b load=%b alu=%b imm=%b wr=%b pc=%b halt=%b trap=%b cause=%b cnt=%0d",
               name, act.req, act.load, act.alu, act.imm, act.wr, act.pc, act.halted, act.trap, act.cause, act.instret,
               exp.req, exp.load, exp.alu, exp.imm, exp.wr, exp.pc, exp.halted, exp.trap, exp.cause, exp.instret);
    end
  endtask

  logic [31:0] illegal_list [4];

  initial begin
    repeat (3) cyc(1'b1, 1'b0, 32'd0);

    exp_cnt = 32'd0;
    push(1'b1, 1'b0, 32'd0, mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));
    add_instr(I_ADD,         4'b0010, 1'b0, 1'b1); // add  x3,x1,x2
    add_instr(32'h4020_81B3, 4'b0110, 1'b0, 1'b1); // sub  x3,x1,x2
    add_instr(32'h0050_0093, 4'b0010, 1'b1, 1'b1); // addi x1,x0,5
    add_instr(32'h0020_8033, 4'b0010, 1'b0, 1'b0); // add  x0,x1,x2
    add_instr(32'h4030_D093, 4'b1000, 1'b1, 1'b1); // srai x1,x1,3
    add_instr(32'h0020_B1B3, 4'b1001, 1'b0, 1'b1); // sltu
    add_instr(32'h0FF0_C093, 4'b0011, 1'b1, 1'b1); // xori
    add_instr(32'hFFF0_F093, 4'b0000, 1'b1, 1'b1); // andi x1,x1,-1
    add_instr(32'h0020_E1B3, 4'b0001, 1'b0, 1'b1); // or
    add_instr(32'h0020_D1B3, 4'b0101, 1'b0, 1'b1); // srl
    add_instr(32'h0020_91B3, 4'b0100, 1'b0, 1'b1); // sll
    add_instr(32'h0050_A093, 4'b0111, 1'b1, 1'b1); // slti

    for (int k = 0; k < vecs.size(); k++) begin
      cyc(vecs[k].rst, vecs[k].vld, vecs[k].inst);
      check($sformatf("vec%0d", k), vecs[k].exp);
    end

    // 15 empty fetch cycles, then valid on the last allowed cycle
    repeat (15) cyc(1'b0, 1'b0, 32'd0);
    check("wait15", mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, exp_cnt));
    cyc(1'b0, 1'b1, I_ADD);
    check("late_valid", mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, exp_cnt));
    repeat (3) cyc(1'b0, 1'b0, 32'd0);
    check("late_wb", mk(1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, exp_cnt));
    exp_cnt = exp_cnt + 32'd1;

    // 16 empty fetch cycles trap on timeout
    repeat (16) cyc(1'b0, 1'b0, 32'd0);
    check("wait16", mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, exp_cnt));
    cyc(1'b0, 1'b1, I_ADD);
    check("timeout_trap", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, exp_cnt));
    repeat (3) cyc(1'b0, 1'b1, I_ADD);
    check("trap_sticky", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, exp_cnt));

    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    check("reset_clear", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));

    illegal_list[0] = 32'hFFFF_FFFF;
    illegal_list[1] = 32'h0220_81B3; // R-type funct7=0000001
    illegal_list[2] = 32'h4010_9093; // slli with funct7=0100000
    illegal_list[3] = 32'h4020_C1B3; // xor with funct7=0100000
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, illegal_list[k]);
      cyc(1'b0, 1'b1, I_ADD);
      check($sformatf("ill%0d_decode", k), mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));
      cyc(1'b0, 1'b1, I_ADD);
      check($sformatf("ill%0d_trap", k), mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'd0));
      cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 32'd0);
    end

    cyc(1'b0, 1'b1, I_ECALL);
    cyc(1'b0, 1'b1, I_ADD);
    cyc(1'b0, 1'b1, I_ADD);
    check("ecall_halt", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0));
    repeat (3) cyc(1'b0, 1'b1, I_ADD);
    check("halt_sticky", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0));
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    check("halt_reset", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));
    cyc(1'b0, 1'b1, I_ADD);
    check("restart_fetch", mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));

    // reset lands while the add is in EXECUTE
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    check("rst_in_ex", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));
    cyc(1'b1, 1'b0, 32'd0);
    check("rst_after_ex", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));
    cyc(1'b0, 1'b0, 32'd0);
    check("rst_resume", mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));
    cyc(1'b0, 1'b0, 32'd0);
    check("rst_no_pulse", mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
